// File: rtl/control_sequencer.sv
// control_sequencer
//
// Control unit for the Harvard-architecture CPU. Owns the fetch/exec1/exec2
// state register, decodes the 4-bit opcode into datapath strobes and, when
// enabled, keeps a hardware return-address stack for JMS/BBL calls.
//
// Build option:
//   CTRL_RET_STACK_EN - when defined, the return stack, JMS/BBL, ret_sel,
//                       ret_addr and stack_err are active. When undefined,
//                       JMS/BBL decode as NOPs and those outputs are tied 0.
//
// Parameters:
//   ADDR_W       program-counter / return-address width
//   STACK_DEPTH  number of return-stack entries (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   inst       opcode of current instruction, stable fetch..exec2
//   eq         accumulator-equal flag from the ALU
//   pc_in      current PC value (return address source)
//   start      resume pulse, only looked at while halted
//   state      one-hot {exec2, exec1, fetch}, 000 while halted
//   acc_load, e, WrEn, pc_load, pc_inc, ld_mux   datapath strobes
//   ret_sel    PC load source is ret_addr (otherwise operand)
//   ret_addr   top of return stack, 0 when empty
//   halted     high in HALT state
//   stack_err  sticky overflow/underflow flag, cleared only by reset

module control_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        inst,
    input  logic              eq,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              start,
    output logic [2:0]        state,
    output logic              acc_load,
    output logic              e,
    output logic              WrEn,
    output logic              pc_load,
    output logic              pc_inc,
    output logic              ld_mux,
    output logic              ret_sel,
    output logic [ADDR_W-1:0] ret_addr,
    output logic              halted,
    output logic              stack_err
);

    localparam logic [3:0] OP_LDI = 4'b0000;
    localparam logic [3:0] OP_STA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_STP = 4'b0100;
    localparam logic [3:0] OP_LDA = 4'b0101;
    localparam logic [3:0] OP_JMS = 4'b0110;
    localparam logic [3:0] OP_BBL = 4'b0111;
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_JEQ = 4'b1110;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

    seq_state_t cur_state;
    seq_state_t next_state;

    logic first_fetch;
    logic strobe_en;
    logic in_exec1;
    logic in_exec2;
    logic stack_jmp;

    logic is_ldi, is_sta, is_add, is_jmp, is_stp;
    logic is_lda, is_jms, is_bbl, is_ldr, is_jeq;
    logic is_mem_read;

    assign is_ldi = (inst == OP_LDI);
    assign is_sta = (inst == OP_STA);
    assign is_add = (inst == OP_ADD);
    assign is_jmp = (inst == OP_JMP);
    assign is_stp = (inst == OP_STP);
    assign is_lda = (inst == OP_LDA);
    assign is_jms = (inst == OP_JMS);
    assign is_bbl = (inst == OP_BBL);
    assign is_ldr = (inst == OP_LDR);
    assign is_jeq = (inst == OP_JEQ);

    // Instructions that need the EXEC2 cycle to read the operand into the accumulator.
    assign is_mem_read = is_lda | is_add | is_ldr;

    // Strobes are suppressed while reset is high and for the first FETCH after
    // it, so a reset mid-instruction never leaks a partial strobe and the
    // decoder sees a clean instruction boundary.
    assign strobe_en = ~reset & ~first_fetch;
    assign in_exec1  = strobe_en & (cur_state == EXEC1);
    assign in_exec2  = strobe_en & (cur_state == EXEC2);

    // State register plus the post-reset marker; every clock after reset
    // leaves FETCH, so the marker only needs to live for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= FETCH;
            first_fetch <= 1'b1;
        end else begin
            cur_state   <= next_state;
            first_fetch <= 1'b0;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        next_state = cur_state;
        acc_load   = 1'b0;
        e          = 1'b0;
        WrEn       = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        ld_mux     = 1'b0;

        case (cur_state)
            FETCH: next_state = EXEC1;
            EXEC1: begin
                if (is_mem_read)
                    next_state = EXEC2;
                else if (is_stp)
                    next_state = HALT;
                else
                    next_state = FETCH;
            end
            EXEC2: next_state = FETCH;
            HALT: begin
                if (start)
                    next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase

        e        = strobe_en & is_mem_read;
        ld_mux   = strobe_en & is_ldi;
        WrEn     = in_exec1 & is_sta;
        acc_load = (in_exec1 & is_ldi) | (in_exec2 & is_mem_read);
        pc_load  = in_exec1 & (is_jmp | (is_jeq & eq) | stack_jmp);
        // A refused JMS/BBL (full/empty) falls through to a plain increment.
        pc_inc   = in_exec1 & ~is_stp & ~pc_load;
    end

    // One-hot state view for the datapath; HALT shows as all zeros.
    always_comb begin
        state = 3'b000;
        case (cur_state)
            FETCH:   state = 3'b001;
            EXEC1:   state = 3'b010;
            EXEC2:   state = 3'b100;
            default: state = 3'b000;
        endcase
    end

    assign halted = (cur_state == HALT);

`ifdef CTRL_RET_STACK_EN
    localparam int PTR_W = $clog2(STACK_DEPTH + 1);

    logic [PTR_W-1:0]  sp;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              err_event;

    assign full      = (sp == PTR_W'(STACK_DEPTH));
    assign empty     = (sp == '0);
    assign push      = in_exec1 & is_jms & ~full;
    assign pop       = in_exec1 & is_bbl & ~empty;
    assign err_event = in_exec1 & ((is_jms & full) | (is_bbl & empty));
    assign stack_jmp = push | pop;
    assign ret_sel   = pop;

    // Return stack: the entry at index sp is the next free slot, so a push
    // writes there and bumps sp; a pop only moves sp back. Reset empties it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp        <= '0;
            stack_err <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++)
                stack_mem[i] <= '0;
        end else begin
            if (push) begin
                for (int i = 0; i < STACK_DEPTH; i++)
                    if (sp == PTR_W'(i))
                        stack_mem[i] <= pc_in + ADDR_W'(1);
                sp <= sp + PTR_W'(1);
            end else if (pop) begin
                sp <= sp - PTR_W'(1);
            end
            if (err_event)
                stack_err <= 1'b1;
        end
    end

    // Top of stack is entry sp-1; empty stack reads as 0.
    always_comb begin
        ret_addr = '0;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (sp == PTR_W'(i + 1))
                ret_addr = stack_mem[i];
    end
`else
    logic unused_stack;

    assign stack_jmp    = 1'b0;
    assign ret_sel      = 1'b0;
    assign ret_addr     = '0;
    assign stack_err    = 1'b0;
    assign unused_stack = (^{pc_in, is_jms, is_bbl}) ^ (STACK_DEPTH > 0);
`endif

endmodule
